ins_sequencer: RTL



---
 rtl/ins_seq_pkg.sv | 12 +
 rtl/ins_mem.sv | 24 ++
 rtl/ins_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ins_seq_pkg.sv
// Shared state encoding and default parameters for the instruction sequencer.
package ins_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} seq_state_t;

  localparam int DEF_INS_W    = 16;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_HOLD     = 10;
  localparam int DEF_PRIME    = 2;
  localparam int DEF_ACK_MODE = 0;

endpackage

// File: rtl/ins_mem.sv
// Program memory: synchronous write, combinational read, no reset on contents.
// Zero read latency; the sequencer registers read data into its ins output.
module ins_mem #(
  parameter int INS_W = 16,
  parameter int DEPTH = 32,
  parameter int PA_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PA_W-1:0]  waddr,
  input  logic [INS_W-1:0] wdata,
  input  logic [PA_W-1:0]  raddr,
  output logic [INS_W-1:0] rdata
);

  logic [INS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ins_sequencer.sv
// Replays stored instructions into the CPU: PRIME cycles of en_in, then each word held HOLD cycles
// or until en_ram_in (ACK_MODE=1); ins/pc update one cycle after the advance condition.
module ins_sequencer
  import ins_seq_pkg::*;
#(
  parameter int INS_W    = DEF_INS_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PA_W     = $clog2(DEPTH),
  parameter int HOLD     = DEF_HOLD,
  parameter int PRIME    = DEF_PRIME,
  parameter int ACK_MODE = DEF_ACK_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PA_W-1:0]  wr_addr,
  input  logic [INS_W-1:0] wr_data,
  input  logic [PA_W:0]    prog_len,
  input  logic             start,
  input  logic             loop,
  input  logic             stop,
  input  logic             en_ram_in,
  output logic             en_in,
  output logic             en_ram_out,
  output logic [INS_W-1:0] ins,
  output logic [PA_W-1:0]  pc,
  output logic             busy,
  output logic             done
);

  localparam int HW_W = $clog2(HOLD + 1);
  localparam int PR_W = $clog2(PRIME + 1);
  localparam logic [HW_W-1:0] HOLD_LAST  = HW_W'(HOLD - 1);
  localparam logic [PR_W-1:0] PRIME_LAST = PR_W'(PRIME - 1);
  localparam logic [PA_W:0]   LEN_ONE    = (PA_W + 1)'(1);
  localparam logic [PA_W:0]   LEN_MAX    = (PA_W + 1)'(DEPTH);

  seq_state_t       state, state_nxt;
  logic [HW_W-1:0]  hold_cnt;
  logic [PR_W-1:0]  prime_cnt;
  logic [PA_W:0]    len;
  logic             loop_q;
  logic [PA_W-1:0]  rd_addr;
  logic [INS_W-1:0] rd_data;
  logic             advance, last, prime_end;

  ins_mem #(.INS_W(INS_W), .DEPTH(DEPTH), .PA_W(PA_W)) u_mem (
    .clk   (clk),
    .we    (wr_en && (state == S_IDLE)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    en_in      = 1'b0;
    en_ram_out = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    advance    = 1'b0;
    rd_addr    = '0;
    last       = ({1'b0, pc} == (len - LEN_ONE));
    prime_end  = (prime_cnt == PRIME_LAST);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (prog_len == '0) ? S_DONE : S_PRIME;
      end
      S_PRIME: begin
        en_in = 1'b1;
        busy  = 1'b1;
        if (stop)           state_nxt = S_IDLE;
        else if (prime_end) state_nxt = S_RUN;
      end
      S_RUN: begin
        en_in      = 1'b1;
        en_ram_out = 1'b1;
        busy       = 1'b1;
        advance    = (ACK_MODE != 0) ? en_ram_in : (hold_cnt == HOLD_LAST);
        // Wrap and exit both read address 0, so only a mid-program step needs pc+1.
        rd_addr    = last ? '0 : pc + PA_W'(1);
        if (stop)                            state_nxt = S_IDLE;
        else if (advance && last && !loop_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      prime_cnt <= '0;
      len       <= '0;
      loop_q    <= 1'b0;
      ins       <= '0;
      pc        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (prog_len != '0)) begin
            len       <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
            loop_q    <= loop;
            prime_cnt <= '0;
            hold_cnt  <= '0;
          end
        end
        S_PRIME: begin
          if (stop) begin
            prime_cnt <= '0;
          end else if (prime_end) begin
            ins       <= rd_data;
            pc        <= '0;
            prime_cnt <= '0;
            hold_cnt  <= '0;
          end else begin
            prime_cnt <= prime_cnt + PR_W'(1);
          end
        end
        S_RUN: begin
          if (stop) begin
            ins      <= '0;
            pc       <= '0;
            hold_cnt <= '0;
          end else if (advance) begin
            hold_cnt <= '0;
            if (last && !loop_q) begin
              ins <= '0;
              pc  <= '0;
            end else begin
              ins <= rd_data;
              pc  <= last ? '0 : pc + PA_W'(1);
            end
          end else if (ACK_MODE == 0) begin
            hold_cnt <= hold_cnt + HW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
